// File: rtl/osc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : osc_pkg
// Purpose  : Shared channel mode enum and default sizing for multi_oscillator.
// Revision : 1.0 - initial release
// ============================================================================
package osc_pkg;

    localparam int c_NUM_CH_DEFAULT  = 4;
    localparam int c_DIV_W_DEFAULT   = 8;
    localparam int c_PHASE_W_DEFAULT = 8;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } MODE_TYPES;

endpackage
`default_nettype wire

// File: rtl/osc_channel.sv
`default_nettype none
// ============================================================================
// Module   : osc_channel
// Purpose  : One tone channel: clock divider stepping a sawtooth phase.
// Revision : 1.0 - initial release
// ============================================================================
module osc_channel
    import osc_pkg::*;
#(
    parameter int DIV_W   = c_DIV_W_DEFAULT,
    parameter int PHASE_W = c_PHASE_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_play,
    input  logic [DIV_W-1:0]   i_freq,
    output logic               o_at_max,
    output logic [PHASE_W-1:0] o_saw,
    output logic               o_square,
    output MODE_TYPES          o_state
);

    logic [DIV_W-1:0]   r_div_cnt;
    logic [PHASE_W-1:0] r_phase;
    logic               w_active;
    logic               w_wrap;

    assign w_active = i_play && (i_freq != '0);
    // Compare against the live freq so a shortened period wraps on the next edge.
    assign w_wrap   = (r_div_cnt >= (i_freq - DIV_W'(1)));

    always_ff @(posedge clk) begin
        if (rst || !w_active) begin
            r_div_cnt <= '0;
            r_phase   <= '0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_phase   <= r_phase + PHASE_W'(1);
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    assign o_at_max = w_active && w_wrap;
    assign o_saw    = r_phase;
    assign o_square = r_phase[PHASE_W-1];
    assign o_state  = w_active ? ON : OFF;

endmodule
`default_nettype wire

// File: rtl/multi_oscillator.sv
`default_nettype none
// ============================================================================
// Module   : multi_oscillator
// Purpose  : NUM_CH independent tone channels with optional registered mixer
//            (mixer built only when OSC_MIX_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module multi_oscillator
    import osc_pkg::*;
#(
    parameter int NUM_CH  = c_NUM_CH_DEFAULT,
    parameter int DIV_W   = c_DIV_W_DEFAULT,
    parameter int PHASE_W = c_PHASE_W_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                play,
    input  logic [NUM_CH*DIV_W-1:0]          freq,
    output logic [NUM_CH-1:0]                at_max,
    output logic [NUM_CH*PHASE_W-1:0]        saw,
    output logic [NUM_CH-1:0]                square,
    output logic [NUM_CH-1:0]                state,
    output logic [PHASE_W+$clog2(NUM_CH):0]  mix
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        MODE_TYPES w_state;

        osc_channel #(
            .DIV_W   (DIV_W),
            .PHASE_W (PHASE_W)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .i_play   (play[i]),
            .i_freq   (freq[i*DIV_W +: DIV_W]),
            .o_at_max (at_max[i]),
            .o_saw    (saw[i*PHASE_W +: PHASE_W]),
            .o_square (square[i]),
            .o_state  (w_state)
        );

        assign state[i] = w_state;
    end

`ifdef OSC_MIX_EN
    localparam int c_MIX_W = PHASE_W + $clog2(NUM_CH) + 1;

    logic [c_MIX_W-1:0] w_mix_sum;
    logic [c_MIX_W-1:0] r_mix;

    // A channel just turned off still shows its old phase for one cycle; gate on state.
    always_comb begin
        w_mix_sum = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (state[k]) begin
                w_mix_sum = w_mix_sum + c_MIX_W'(saw[k*PHASE_W +: PHASE_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mix <= '0;
        end else begin
            r_mix <= w_mix_sum;
        end
    end

    assign mix = r_mix;
`else
    assign mix = '0;
`endif

endmodule
`default_nettype wire

// File: doc/multi_oscillator.md
MULTI_OSCILLATOR -- requirements
Module: multi_oscillator

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent tone channels, range 1..8.
REQ-002 SHALL have parameter DIV_W, default 8: width of each channel's divider count and freq input.
REQ-003 SHALL have parameter PHASE_W, default 8: width of each channel's phase accumulator (waveform resolution).
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port play  input  NUM_CH: per-channel enable; bit i gates channel i.
REQ-007 SHALL have port freq  input  NUM_CH x DIV_W: per-channel divider period in clk cycles per phase step.
REQ-008 SHALL have port at_max  output  NUM_CH: per-channel divider-wrap indication.
REQ-009 SHALL have port saw  output  NUM_CH x PHASE_W: per-channel phase value (sawtooth).
REQ-010 SHALL have port square  output  NUM_CH: per-channel phase MSB (square wave).
REQ-011 SHALL have port state  output  NUM_CH: per-channel MODE_TYPES; ON when active, OFF otherwise.
REQ-012 SHALL have port mix  output  PHASE_W+$clog2(NUM_CH)+1: sum of active channels' saw values.

Function
REQ-013 Channel i is active exactly when play[i]=1 and freq[i]!=0; state[i] is the combinational decode of that condition.
REQ-014 Active channel, each edge: div_cnt <= (div_cnt >= freq-1) ? 0 : div_cnt+1; on the wrap edge, phase <= phase+1 modulo 2^PHASE_W.
REQ-015 at_max[i] = active and div_cnt >= freq-1, combinational from registered div_cnt; it is high for exactly one cycle in every freq[i] cycles.
REQ-016 The first at_max after activation from div_cnt=0 asserts after freq-1 edges; a steady period of freq cycles follows.
REQ-017 A freq change mid-count takes effect immediately; if div_cnt >= new freq-1, the next edge wraps (no 2^DIV_W rollover).
REQ-018 freq=1 wraps every edge: at_max held high, phase steps every cycle.
REQ-019 Inactive channel: next edge clears div_cnt and phase to 0; at_max, saw, square read 0 from then on.
REQ-020 A channel with play=1 and freq=0 is inactive (silent) with no ticks.
REQ-021 saw[i] = phase[i]; square[i] = phase[i][PHASE_W-1].
REQ-022 Channels are fully independent; no shared counters.

Reset
REQ-023 rst=1 at an edge clears all div_cnt, phase and mix registers to 0; rst overrides play.
REQ-024 Outputs after reset: at_max=0, saw=0, square=0, state follows REQ-013, mix=0.
REQ-025 Reset asserted mid-operation aborts all channels; counting resumes from 0 on the first edge with rst=0.

Configuration
REQ-026 Macro OSC_MIX_EN defined: mix is a register loaded each edge with the sum of saw over active channels (one-cycle latency, no overflow given its width).
REQ-027 OSC_MIX_EN undefined: mix port is present and tied to 0; no mixer logic is built.

Structure
REQ-028 Package osc_pkg SHALL hold the MODE_TYPES enum (OFF=1'b0, ON=1'b1) and the default values of NUM_CH, DIV_W and PHASE_W.
REQ-029 Sub-module osc_channel SHALL implement one channel (REQ-013..REQ-021), instantiated NUM_CH times by a generate loop; the mixer stays in the top level.

Verification
REQ-030 Channel 0, freq=89, play=1 after reset: first at_max after 88 edges, then every 89 cycles; square toggles every 128*89 cycles.
REQ-031 freq=149 running, change to freq=4 when div_cnt=100: wrap on the next edge, then period 4; other channels unaffected.
REQ-032 play=0 with freq=149 for 300 cycles, then freq=0 with play=1: at_max, saw, square stay 0 and state=OFF throughout.
REQ-033 rst pulsed 1 cycle while channels run at freq 89/126: all counters 0 the next cycle; phase 1 reached 89 and 126 cycles after release.
REQ-034 OSC_MIX_EN with channels 0,1 at freq=1: mix equals saw0+saw1 from the previous cycle; at phase 255+255, mix=510 with no wrap.
REQ-035 freq=1 on a channel: at_max continuously high and saw increments every cycle, wrapping 255->0.
